// File: rtl/subtractor_32bits_serial.sv
// subtractor_32bits_serial: digit-serial a - b - borrow_in with start/ready and valid/ack handshakes
module subtractor_32bits_serial #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_in_brw,
    input  logic             ack_in,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             brw_o,
    output logic             ovf_o
);
    localparam int NSTEP = WIDTH / DIGIT_W;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_nb, r_acc, r_diff;
    logic               r_c, r_brw, r_ovf, r_a_msb, r_b_msb;
    logic [SW-1:0]      r_step;
    logic [DIGIT_W:0]   w_sum;
    logic               w_last;

    assign w_sum   = {1'b0, r_a[DIGIT_W-1:0]} + {1'b0, r_nb[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, r_c};
    assign w_last  = r_step == SW'(NSTEP - 1);
    assign ready_o = r_state == S_IDLE;
    assign valid_o = r_state == S_DONE;
    assign diff_o  = r_diff;
    assign brw_o   = r_brw;
    assign ovf_o   = r_ovf;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next state: accept in IDLE, run NSTEP digits, hold result until ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start_in ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = ack_in ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, add one digit of a + ~b per RUN cycle, publish on the last digit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_a     <= '0;
            r_nb    <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_c     <= 1'b0;
            r_brw   <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_step  <= '0;
        end else if (r_state == S_IDLE && start_in) begin
            r_a     <= a_in;
            r_nb    <= ~b_in;
            r_c     <= ~b_in_brw;
            r_a_msb <= a_in[WIDTH-1];
            r_b_msb <= b_in[WIDTH-1];
            r_acc   <= '0;
            r_step  <= '0;
        end else if (r_state == S_RUN) begin
            r_a    <= r_a >> DIGIT_W;
            r_nb   <= r_nb >> DIGIT_W;
            r_c    <= w_sum[DIGIT_W];
            r_acc  <= {w_sum[DIGIT_W-1:0], r_acc[WIDTH-1:DIGIT_W]};
            r_step <= r_step + SW'(1);
            if (w_last) begin
                r_diff <= {w_sum[DIGIT_W-1:0], r_acc[WIDTH-1:DIGIT_W]};
                r_brw  <= ~w_sum[DIGIT_W];
                r_ovf  <= (r_a_msb != r_b_msb) & (w_sum[DIGIT_W-1] != r_a_msb);
            end
        end
    end
endmodule
